// File: rtl/add_serial_m.sv
// M-lane bit-serial adder/subtractor: one full-adder cell per lane, LSB first,
// W cycles per operand set, valid/ready handshake on both sides.
module add_serial_m #(
    parameter int M = 16,
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic         sub_i,
    input  logic [W-1:0] a_i     [0:M-1],
    input  logic [W-1:0] b_i     [0:M-1],
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] sum_o   [0:M-1],
    output logic         carry_o [0:M-1],
    output logic         ovf_o   [0:M-1],
    output logic         busy_o
);

    localparam int CW = (W < 1) ? 1 : $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sub_q, sub_d;
    logic [W-1:0]  a_q   [0:M-1];
    logic [W-1:0]  a_d   [0:M-1];
    logic [W-1:0]  b_q   [0:M-1];
    logic [W-1:0]  b_d   [0:M-1];
    logic [W-1:0]  res_q [0:M-1];
    logic [W-1:0]  res_d [0:M-1];
    logic [W-1:0]  sum_q [0:M-1];
    logic [W-1:0]  sum_d [0:M-1];
    logic [M-1:0]  c_q, c_d, carry_q, carry_d, ovf_q, ovf_d;
    logic [M-1:0]  fa_s, fa_co;
    logic          last;

    assign last    = (cnt_q == CW'(W - 1));
    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q == RUN);
    assign valid_o = (state_q == DONE);

    // Shift a new bit into the MSB end; the result lands LSB-aligned after W shifts.
    function automatic logic [W-1:0] shift_in(input logic [W-1:0] v, input logic s);
        logic [W-1:0] r;
        r        = v >> 1;
        r[W-1]   = s;
        return r;
    endfunction

    for (genvar i = 0; i < M; i++) begin : g_lane
        logic b_eff;
        assign b_eff     = b_q[i][0] ^ sub_q;
        assign fa_s[i]   = a_q[i][0] ^ b_eff ^ c_q[i];
        assign fa_co[i]  = (a_q[i][0] & b_eff) | ((a_q[i][0] ^ b_eff) & c_q[i]);
        assign sum_o[i]  = sum_q[i];
        assign carry_o[i] = carry_q[i];
        assign ovf_o[i]  = ovf_q[i];
    end

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        c_d     = c_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    sub_d   = sub_i;
                    c_d     = {M{sub_i}};
                    for (int i = 0; i < M; i++) begin
                        a_d[i] = a_i[i];
                        b_d[i] = b_i[i];
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                c_d   = fa_co;
                for (int i = 0; i < M; i++) begin
                    a_d[i]   = a_q[i] >> 1;
                    b_d[i]   = b_q[i] >> 1;
                    res_d[i] = shift_in(res_q[i], fa_s[i]);
                    if (last) sum_d[i] = res_d[i];
                end
                if (last) begin
                    // Signed overflow: carry into the MSB differs from carry out of it.
                    carry_d = fa_co;
                    ovf_d   = c_q ^ fa_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the shift/result arrays are small flop banks, not RAM, so they are reset like any register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
            c_q     <= '0;
            carry_q <= '0;
            ovf_q   <= '0;
            for (int i = 0; i < M; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                res_q[i] <= '0;
                sum_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
        end
    end

endmodule
